sprite_layer_compositor: RTL and testbench
==========================================

Name: sprite_layer_compositor

Overview:
- Parametrised successor to the four-layer sprite merger.
- Holds one pending pixel per sprite layer in registered layer slots and resolves priority plus transparency in a 2-stage pipeline.
- Emits one composited RGB pixel per compose request. Sits between the sprite memory readers and the video output/DAC formatter.

Parameters:
- NUM_LAYERS, 4, number of sprite layer slots (2..16)
- CH_W, 8, bits per colour channel; pixel width PIX_W = 3*CH_W
- LAYER_W, 5, width of the layer index input
- TRANSP_KEY, 24'h000011, colour treated as transparent (width PIX_W)
- BG_COLOR, 24'h000000, pixel emitted when no layer is opaque

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe for a layer slot
- wr_layer  in  LAYER_W  target slot index
- wr_data  in  PIX_W  sprite pixel {B,G,R}
- compose_start  in  1  request composition of the current slot contents
- pixel  out  PIX_W  composited pixel
- pixel_valid  out  1  one-cycle strobe, pixel/Saida_* valid
- Saida_R  out  CH_W  pixel[CH_W-1:0]
- Saida_G  out  CH_W  pixel[2*CH_W-1:CH_W]
- Saida_B  out  CH_W  pixel[3*CH_W-1:2*CH_W]
- layer_err  out  1  sticky: a write addressed a slot >= NUM_LAYERS

Behaviour:
- Reset: all slot data = TRANSP_KEY, all slot valid flags = 0, pixel = BG_COLOR, Saida_* = BG_COLOR fields, pixel_valid = 0, layer_err = 0, pipeline valids = 0.
- Write: with wr_en=1 and wr_layer < NUM_LAYERS, slot[wr_layer] <= wr_data and valid[wr_layer] <= 1 on the next edge. A later write to the same slot overwrites it.
- Out-of-range write: the slot array is unchanged and layer_err <= 1. layer_err clears only on reset.
- Stage 1 (snapshot): on compose_start, the slot data and valid flags are copied into snapshot registers, and all valid flags clear (auto-clear per pixel).
- Simultaneous write and compose_start: the snapshot takes the pre-write contents. The written slot ends with the new data and valid=1, i.e. the write survives the clear.
- Stage 2 (resolve): a slot is opaque when valid=1 and data != TRANSP_KEY. The lowest-index opaque slot wins (layer 0 is front-most). If no slot is opaque, the result is BG_COLOR.
- Latency: compose_start at edge t gives pixel_valid=1 with the result at edge t+2. Full throughput: compose_start may assert every cycle.
- Outputs hold their last value when pixel_valid=0.
- Reset mid-pipeline discards in-flight requests; no pixel_valid is emitted for them.
- Everything is fully synchronous; the design contains no combinational latches.

Optional Feature:
- Macro SPRITE_LAYER_MASK_EN.
- Defined: adds input layer_mask [NUM_LAYERS-1:0], sampled into stage 1 with the snapshot. A slot whose mask bit is 0 is treated as transparent in stage 2; its slot data is unaffected.
- Undefined: the port is absent and every slot participates.

Decomposition:
- Package sprite_pkg: default TRANSP_KEY and BG_COLOR constants, a channel-slice helper for R/G/B extraction, and the layer-index width constant.
- One sub-module, sprite_priority_mux: a purely combinational lowest-index-opaque select over NUM_LAYERS entries, instantiated in stage 2.

Test Plan:
- Reset then compose_start with no writes -> at t+2 pixel=24'h000000, pixel_valid=1, layer_err=0.
- Write L2=24'hFF0000 and L1=24'h00FF00, then compose -> pixel=24'h00FF00, Saida_G=8'hFF, Saida_R=8'h00.
- Write L0=24'h000011 (key) and L3=24'h123456, then compose -> pixel=24'h123456. A second compose with no writes -> 24'h000000 (auto-clear).
- Same cycle as compose: write L0=24'hABCDEF with slots empty -> first result BG_COLOR, next compose -> 24'hABCDEF.
- Write wr_layer=7 with NUM_LAYERS=4 -> layer_err=1 and stays 1, slots unchanged. Assert reset -> layer_err=0.
- compose_start on 3 back-to-back cycles, with reset asserted in the 2nd cycle -> only the 3rd request yields pixel_valid, 2 cycles after it.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and helpers for the sprite layer compositor.
package sprite_pkg;

  localparam int LAYER_IDX_W = 5;
  localparam int MAX_CH_W    = 16;
  localparam int MAX_PIX_W   = 3 * MAX_CH_W;

  localparam logic [23:0] DEF_TRANSP_KEY = 24'h000011;
  localparam logic [23:0] DEF_BG_COLOR   = 24'h000000;

  // Extract channel 'ch' (0=R, 1=G, 2=B) of width ch_w from a zero-extended pixel
  function automatic logic [MAX_CH_W-1:0] ch_slice(input logic [MAX_PIX_W-1:0] pix,
                                                   input int ch, input int ch_w);
    logic [MAX_PIX_W-1:0] sh;
    sh = pix >> (ch * ch_w);
    return sh[MAX_CH_W-1:0] & ((MAX_CH_W'(1) << ch_w) - MAX_CH_W'(1));
  endfunction

endpackage

// File: rtl/sprite_priority_mux.sv
// Combinational front-to-back select: lowest-index opaque entry wins,
// background colour when nothing is opaque.
module sprite_priority_mux
  import sprite_pkg::*;
#(
  parameter int               NUM_LAYERS = 4,
  parameter int               PIX_W      = 24,
  parameter logic [PIX_W-1:0] TRANSP_KEY = PIX_W'(DEF_TRANSP_KEY),
  parameter logic [PIX_W-1:0] BG_COLOR   = PIX_W'(DEF_BG_COLOR)
) (
  input  logic [NUM_LAYERS-1:0][PIX_W-1:0] data,
  input  logic [NUM_LAYERS-1:0]            vld,
  output logic [PIX_W-1:0]                 pix
);

  // Scan back to front so the front-most opaque layer is the last assignment
  always_comb begin
    pix = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (vld[i] && (data[i] != TRANSP_KEY)) pix = data[i];
    end
  end

endmodule

// File: rtl/sprite_layer_compositor.sv
// Sprite layer compositor: per-layer pending pixel slots, snapshot on
// compose_start (stage 1), priority/transparency resolve into the output
// register (stage 2). Optional layer mask input: SPRITE_LAYER_MASK_EN.
module sprite_layer_compositor
  import sprite_pkg::*;
#(
  parameter int                  NUM_LAYERS = 4,
  parameter int                  CH_W       = 8,
  parameter int                  LAYER_W    = LAYER_IDX_W,
  parameter logic [3*CH_W-1:0]   TRANSP_KEY = (3*CH_W)'(DEF_TRANSP_KEY),
  parameter logic [3*CH_W-1:0]   BG_COLOR   = (3*CH_W)'(DEF_BG_COLOR)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [LAYER_W-1:0]    wr_layer,
  input  logic [3*CH_W-1:0]     wr_data,
  input  logic                  compose_start,
`ifdef SPRITE_LAYER_MASK_EN
  input  logic [NUM_LAYERS-1:0] layer_mask,
`endif
  output logic [3*CH_W-1:0]     pixel,
  output logic                  pixel_valid,
  output logic [CH_W-1:0]       Saida_R,
  output logic [CH_W-1:0]       Saida_G,
  output logic [CH_W-1:0]       Saida_B,
  output logic                  layer_err
);

  localparam int PIX_W = 3 * CH_W;

  logic [NUM_LAYERS-1:0][PIX_W-1:0] slot_q, slot_d;
  logic [NUM_LAYERS-1:0]            slot_vld_q, slot_vld_d;
  logic [NUM_LAYERS-1:0][PIX_W-1:0] snap_q, snap_d;
  logic [NUM_LAYERS-1:0]            snap_vld_q, snap_vld_d;
  logic [NUM_LAYERS-1:0]            eff_vld;
  logic [1:0]                       vld_pipe_q, vld_pipe_d;
  logic [PIX_W-1:0]                 pixel_q, pixel_d;
  logic                             layer_err_q, layer_err_d;
  logic [PIX_W-1:0]                 mux_pix;
  logic                             wr_in_range;

  assign wr_in_range = (32'(wr_layer) < NUM_LAYERS);

`ifdef SPRITE_LAYER_MASK_EN
  logic [NUM_LAYERS-1:0] snap_mask_q, snap_mask_d;

  // Mask is captured alongside the snapshot so it applies to that pixel only
  always_comb begin
    snap_mask_d = snap_mask_q;
    if (compose_start) snap_mask_d = layer_mask;
  end

  // Mask register
  always_ff @(posedge clock) begin
    if (reset) snap_mask_q <= '1;
    else       snap_mask_q <= snap_mask_d;
  end

  assign eff_vld = snap_vld_q & snap_mask_q;
`else
  assign eff_vld = snap_vld_q;
`endif

  // Slot update, snapshot and stage advance; the write is applied after the
  // auto-clear so a write coinciding with compose_start survives it
  always_comb begin
    slot_d      = slot_q;
    slot_vld_d  = slot_vld_q;
    snap_d      = snap_q;
    snap_vld_d  = snap_vld_q;
    layer_err_d = layer_err_q;
    pixel_d     = pixel_q;
    vld_pipe_d  = {vld_pipe_q[0], compose_start};
    if (compose_start) begin
      snap_d     = slot_q;
      snap_vld_d = slot_vld_q;
      slot_vld_d = '0;
    end
    if (wr_en) begin
      if (wr_in_range) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (wr_layer == LAYER_W'(i)) begin
            slot_d[i]     = wr_data;
            slot_vld_d[i] = 1'b1;
          end
        end
      end else begin
        layer_err_d = 1'b1;
      end
    end
    if (vld_pipe_q[0]) pixel_d = mux_pix;
  end

  sprite_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .PIX_W      (PIX_W),
    .TRANSP_KEY (TRANSP_KEY),
    .BG_COLOR   (BG_COLOR)
  ) u_mux (
    .data (snap_q),
    .vld  (eff_vld),
    .pix  (mux_pix)
  );

  // State registers; reset drops in-flight requests via vld_pipe
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q      <= {NUM_LAYERS{TRANSP_KEY}};
      slot_vld_q  <= '0;
      snap_q      <= {NUM_LAYERS{TRANSP_KEY}};
      snap_vld_q  <= '0;
      vld_pipe_q  <= '0;
      pixel_q     <= BG_COLOR;
      layer_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
      snap_q      <= snap_d;
      snap_vld_q  <= snap_vld_d;
      vld_pipe_q  <= vld_pipe_d;
      pixel_q     <= pixel_d;
      layer_err_q <= layer_err_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = vld_pipe_q[1];
  assign layer_err   = layer_err_q;
  assign Saida_R     = CH_W'(ch_slice(MAX_PIX_W'(pixel_q), 0, CH_W));
  assign Saida_G     = CH_W'(ch_slice(MAX_PIX_W'(pixel_q), 1, CH_W));
  assign Saida_B     = CH_W'(ch_slice(MAX_PIX_W'(pixel_q), 2, CH_W));

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Directed bench for sprite_layer_compositor with a scoreboard of expected pixels.
module tb_sprite_layer_compositor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_layer = '0;
  logic [23:0] wr_data = '0;
  logic        compose_start = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [7:0]  Saida_R, Saida_G, Saida_B;
  logic        layer_err;
`ifdef SPRITE_LAYER_MASK_EN
  logic [3:0]  layer_mask = '1;
`endif

  always #5 clock = ~clock;

  sprite_layer_compositor dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_layer      (wr_layer),
    .wr_data       (wr_data),
    .compose_start (compose_start),
`ifdef SPRITE_LAYER_MASK_EN
    .layer_mask    (layer_mask),
`endif
    .pixel         (pixel),
    .pixel_valid   (pixel_valid),
    .Saida_R       (Saida_R),
    .Saida_G       (Saida_G),
    .Saida_B       (Saida_B),
    .layer_err     (layer_err)
  );

  typedef struct { int due; logic [23:0] pix; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic [23:0] m_slot [4];
  logic        m_vld  [4];
  logic        m_err;
  logic [23:0] m_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] resolve();
    for (int i = 0; i < 4; i++)
      if (m_vld[i] && m_slot[i] != 24'h000011) return m_slot[i];
    return 24'h000000;
  endfunction

  // One clock: drive inputs, update the model, then sample after the edge
  task automatic cycle(input logic we, input int wl, input logic [23:0] wd,
                       input logic cs, input logic rst);
    exp_t e;
    reset = rst; wr_en = we; wr_layer = 5'(wl); wr_data = wd; compose_start = cs;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 4; i++) begin m_slot[i] = 24'h000011; m_vld[i] = 1'b0; end
      m_err = 1'b0;
      m_pix = 24'h000000;
    end else begin
      if (cs) begin
        e.due = cyc + 2;
        e.pix = resolve();
        sb.push_back(e);
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      end
      if (we) begin
        if (wl < 4) begin m_slot[wl] = wd; m_vld[wl] = 1'b1; end
        else m_err = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      m_pix = e.pix;
      chk("pixel_valid", 32'(pixel_valid), 32'd1);
      chk("Saida_R", 32'(Saida_R), 32'(e.pix[7:0]));
      chk("Saida_G", 32'(Saida_G), 32'(e.pix[15:8]));
      chk("Saida_B", 32'(Saida_B), 32'(e.pix[23:16]));
    end else begin
      chk("pixel_valid_idle", 32'(pixel_valid), 32'd0);
    end
    chk("pixel", 32'(pixel), 32'(m_pix));
    chk("layer_err", 32'(layer_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 24'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    cycle(1'b0, 0, 24'h0, 1'b0, 1'b1);
    cycle(1'b0, 0, 24'h0, 1'b0, 1'b1);
    // compose with no writes -> background
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(2);
    // front-most opaque wins
    cycle(1'b1, 2, 24'hFF0000, 1'b0, 1'b0);
    cycle(1'b1, 1, 24'h00FF00, 1'b0, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(2);
    // transparent key on L0 falls through; auto-clear on next compose
    cycle(1'b1, 0, 24'h000011, 1'b0, 1'b0);
    cycle(1'b1, 3, 24'h123456, 1'b0, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(2);
    // write coinciding with compose: snapshot is pre-write, write survives
    cycle(1'b1, 0, 24'hABCDEF, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(2);
    // out-of-range write: sticky error, slots untouched
    cycle(1'b1, 1, 24'hAAAAAA, 1'b0, 1'b0);
    cycle(1'b1, 7, 24'h555555, 1'b0, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 31, 24'h777777, 1'b1, 1'b0);
    idle(2);
    // reset clears error
    cycle(1'b0, 0, 24'h0, 1'b0, 1'b1);
    idle(1);
    // back-to-back composes with reset in the middle
    cycle(1'b1, 3, 24'h0F0F0F, 1'b0, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b1);
    cycle(1'b1, 2, 24'h314159, 1'b0, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(3);
    // overwrite same slot, then full-throughput composes
    cycle(1'b1, 2, 24'h111111, 1'b0, 1'b0);
    cycle(1'b1, 2, 24'h222222, 1'b0, 1'b0);
    cycle(1'b1, 0, 24'h0000AA, 1'b0, 1'b0);
    cycle(1'b1, 0, 24'h0000BB, 1'b1, 1'b0);
    cycle(1'b1, 3, 24'hC0FFEE, 1'b1, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    cycle(1'b0, 0, 24'h0, 1'b1, 1'b0);
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
